hazard_controller: RTL and testbench

- Central pipeline sequencer for the 5-stage pipelined RISC-V core (F/D/E/M/W).
- Drives E-stage operand forwarding selects, stage stall and flush enables.
- Resolves load-use hazards, taken-branch/jump redirects and multi-cycle data-memory waits.
- Single owner of every pipeline register enable and clear; no other block stalls or flushes the pipe.

---
 rtl/hazard_controller.sv | 193 +++++++++++++++++++
 tb/tb_hazard_controller.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_controller.sv
// ----------------------------------------------------------------------------
// hazard_controller
//   Central sequencer for a 5-stage (F/D/E/M/W) RISC-V pipeline. It is the
//   only block that stalls or flushes pipeline registers.
//   - E-stage operand forwarding selects (M has priority over W)
//   - load-use stall, taken-branch/jump flush
//   - data-memory wait FSM (RUN/WAIT/FAULT) with a timeout that raises a
//     sticky fault
//
// Optional feature macro: HAZARD_PERF_CNT_EN
//   Defined   : stall/flush performance counters are built (CNT_W bits, wrap).
//   Undefined : o_StallCount / o_FlushCount are tied to 0.
//
// Ports
//   i_Clk, i_Reset                  clock, synchronous active-high reset
//   i_Rs1D, i_Rs2D                  source regs of instruction in D
//   i_Rs1E, i_Rs2E                  source regs of instruction in E
//   i_RdE, i_RdM, i_RdW             destination regs in E/M/W
//   i_RegWriteM, i_RegWriteW        register-write enables in M/W
//   i_LoadE                         instruction in E is a load
//   i_PCSrcE                        taken branch/jump resolved in E
//   i_MemReqM, i_DMemReady          M-stage access active / completing
//   o_ForwardAE, o_ForwardBE        00 regfile, 01 ResultW, 10 ALUResultM
//   o_StallF..o_StallM              hold stage register
//   o_FlushD, o_FlushE, o_FlushW    clear stage register
//   o_MemFault                      sticky memory-timeout fault
//   o_StallCount, o_FlushCount      performance counters
// ----------------------------------------------------------------------------
module hazard_controller #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             i_Clk,
    input  logic             i_Reset,
    input  logic [4:0]       i_Rs1D,
    input  logic [4:0]       i_Rs2D,
    input  logic [4:0]       i_Rs1E,
    input  logic [4:0]       i_Rs2E,
    input  logic [4:0]       i_RdE,
    input  logic [4:0]       i_RdM,
    input  logic [4:0]       i_RdW,
    input  logic             i_RegWriteM,
    input  logic             i_RegWriteW,
    input  logic             i_LoadE,
    input  logic             i_PCSrcE,
    input  logic             i_MemReqM,
    input  logic             i_DMemReady,
    output logic [1:0]       o_ForwardAE,
    output logic [1:0]       o_ForwardBE,
    output logic             o_StallF,
    output logic             o_StallD,
    output logic             o_StallE,
    output logic             o_StallM,
    output logic             o_FlushD,
    output logic             o_FlushE,
    output logic             o_FlushW,
    output logic             o_MemFault,
    output logic [CNT_W-1:0] o_StallCount,
    output logic [CNT_W-1:0] o_FlushCount
);

    typedef enum logic [1:0] {RUN = 2'd0, WAIT = 2'd1, FAULT = 2'd2} state_e;

    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_e     state_q;
    logic [7:0] cnt_q;

    // ------------------------------------------------------------------
    // Forwarding: independent of stall state so selects stay valid while
    // the pipe is frozen.
    // ------------------------------------------------------------------
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
        if (i_RegWriteM && (i_RdM != 5'd0) && (i_RdM == rs))
            return 2'b10;
        else if (i_RegWriteW && (i_RdW != 5'd0) && (i_RdW == rs))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign o_ForwardAE = fwd_sel(i_Rs1E);
    assign o_ForwardBE = fwd_sel(i_Rs2E);

    // ------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------
    logic mem_wait, mem_done, mem_stall, lw_stall;

    assign mem_wait = i_MemReqM & ~i_DMemReady;
    // Ready without a request is ignored: only a real completion ends WAIT.
    assign mem_done = i_MemReqM & i_DMemReady;
    assign lw_stall = i_LoadE & (i_RdE != 5'd0) &
                      ((i_RdE == i_Rs1D) | (i_RdE == i_Rs2D));

    always_comb begin
        mem_stall = 1'b0;
        case (state_q)
            RUN:     mem_stall = mem_wait;   // stall the same cycle, no bubble
            WAIT:    mem_stall = ~mem_done;  // release on the completing cycle
            FAULT:   mem_stall = 1'b1;
            default: mem_stall = 1'b1;
        endcase
    end

    // Priority: memory stall > branch > load-use. All controls are forced
    // low during the reset cycle.
    always_comb begin
        o_StallF = 1'b0;
        o_StallD = 1'b0;
        o_StallE = 1'b0;
        o_StallM = 1'b0;
        o_FlushD = 1'b0;
        o_FlushE = 1'b0;
        o_FlushW = 1'b0;
        if (!i_Reset) begin
            if (mem_stall) begin
                // Freeze everything; W gets a bubble. Pending branch and
                // load-use resolve once the access completes.
                o_StallF = 1'b1;
                o_StallD = 1'b1;
                o_StallE = 1'b1;
                o_StallM = 1'b1;
                o_FlushW = 1'b1;
            end else if (i_PCSrcE) begin
                o_FlushD = 1'b1;
                o_FlushE = 1'b1;
            end else if (lw_stall) begin
                o_StallF = 1'b1;
                o_StallD = 1'b1;
                o_FlushE = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Memory wait FSM. cnt_q counts WAIT cycles; the RUN cycle that saw the
    // miss is the first wait cycle, so the fault state is entered after
    // MEM_TIMEOUT consecutive waiting cycles.
    // ------------------------------------------------------------------
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q <= RUN;
            cnt_q   <= 8'd0;
        end else begin
            case (state_q)
                RUN: begin
                    cnt_q <= 8'd0;
                    if (mem_wait) state_q <= WAIT;
                end
                WAIT: begin
                    if (mem_done) begin
                        state_q <= RUN;
                        cnt_q   <= 8'd0;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                        if (cnt_q + 8'd1 == WAIT_LAST) state_q <= FAULT;
                    end
                end
                FAULT:   state_q <= FAULT;
                default: state_q <= RUN;
            endcase
        end
    end

    assign o_MemFault = (state_q == FAULT);

    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (o_StallF | o_StallD | o_StallE | o_StallM)
                stall_cnt_q <= stall_cnt_q + 1'b1;
            if (o_FlushD | o_FlushE)
                flush_cnt_q <= flush_cnt_q + 1'b1;
        end
    end

    assign o_StallCount = stall_cnt_q;
    assign o_FlushCount = flush_cnt_q;
`else
    assign o_StallCount = '0;
    assign o_FlushCount = '0;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
module tb_hazard_controller;

    localparam int CNT_W = 32;

    logic clk = 1'b0;
    logic rst;
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic regwm, regww, loade, pcsrce, memreq, dmemrdy;
    logic [1:0] fwda, fwdb;
    logic stf, std, ste, stm, fld, fle, flw, fault;
    logic [CNT_W-1:0] scnt, fcnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_controller #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
        .i_Clk(clk), .i_Reset(rst),
        .i_Rs1D(rs1d), .i_Rs2D(rs2d), .i_Rs1E(rs1e), .i_Rs2E(rs2e),
        .i_RdE(rde), .i_RdM(rdm), .i_RdW(rdw),
        .i_RegWriteM(regwm), .i_RegWriteW(regww),
        .i_LoadE(loade), .i_PCSrcE(pcsrce),
        .i_MemReqM(memreq), .i_DMemReady(dmemrdy),
        .o_ForwardAE(fwda), .o_ForwardBE(fwdb),
        .o_StallF(stf), .o_StallD(std), .o_StallE(ste), .o_StallM(stm),
        .o_FlushD(fld), .o_FlushE(fle), .o_FlushW(flw),
        .o_MemFault(fault),
        .o_StallCount(scnt), .o_FlushCount(fcnt)
    );

    // {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}
    wire [6:0] ctl = {stf, std, ste, stm, fld, fle, flw};

    // Inputs change 1 time unit after a rising edge; outputs are sampled
    // mid-cycle, well away from the edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic idle_inputs();
        rs1d = 0; rs2d = 0; rs1e = 0; rs2e = 0;
        rde = 0; rdm = 0; rdw = 0;
        regwm = 0; regww = 0; loade = 0; pcsrce = 0;
        memreq = 0; dmemrdy = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        next_cycle();
        rst = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        // hazards present during reset must not produce controls
        loade = 1; rde = 5'd3; rs1d = 5'd3; memreq = 1;
        settle();
        checks++;
        if (ctl !== 7'b0000000) begin
            errors++;
            $display("FAIL reset_ctl got %b want %b", ctl, 7'b0000000);
        end
        next_cycle();
        idle_inputs();
        rst = 0;
        settle();
        checks++;
        if (fault !== 1'b0 || ctl !== 7'b0000000) begin
            errors++;
            $display("FAIL reset_state got fault=%b ctl=%b want 0/0000000", fault, ctl);
        end
    endtask

    task automatic test_forwarding();
        next_cycle();
        rdm = 5; rdw = 5; rs1e = 5; rs2e = 5; regwm = 1; regww = 1;
        settle();
        checks++;
        if (fwda !== 2'b10 || fwdb !== 2'b10) begin
            errors++;
            $display("FAIL fwd_m_prio got A=%b B=%b want 10/10", fwda, fwdb);
        end
        regwm = 0;
        settle();
        checks++;
        if (fwda !== 2'b01 || fwdb !== 2'b01) begin
            errors++;
            $display("FAIL fwd_w got A=%b B=%b want 01/01", fwda, fwdb);
        end
        rdm = 0; rdw = 0; rs1e = 0; rs2e = 0; regwm = 1;
        settle();
        checks++;
        if (fwda !== 2'b00 || fwdb !== 2'b00) begin
            errors++;
            $display("FAIL fwd_x0 got A=%b B=%b want 00/00", fwda, fwdb);
        end
        // independent A/B: rs1 from M, rs2 from W
        rdm = 7; rdw = 9; rs1e = 7; rs2e = 9; regwm = 1; regww = 1;
        settle();
        checks++;
        if (fwda !== 2'b10 || fwdb !== 2'b01) begin
            errors++;
            $display("FAIL fwd_split got A=%b B=%b want 10/01", fwda, fwdb);
        end
        idle_inputs();
    endtask

    task automatic test_load_use();
        next_cycle();
        loade = 1; rde = 3; rs2d = 3;
        settle();
        checks++;
        if (ctl !== 7'b1100010) begin
            errors++;
            $display("FAIL lw_stall got %b want %b", ctl, 7'b1100010);
        end
        // the load moves on; hazard gone next cycle
        next_cycle();
        idle_inputs();
        settle();
        checks++;
        if (ctl !== 7'b0000000) begin
            errors++;
            $display("FAIL lw_release got %b want %b", ctl, 7'b0000000);
        end
        // rd = x0 never stalls
        loade = 1; rde = 0; rs1d = 0;
        settle();
        checks++;
        if (ctl !== 7'b0000000) begin
            errors++;
            $display("FAIL lw_x0 got %b want %b", ctl, 7'b0000000);
        end
        idle_inputs();
    endtask

    task automatic test_branch();
        next_cycle();
        loade = 1; rde = 4; rs1d = 4; pcsrce = 1;
        settle();
        checks++;
        if (ctl !== 7'b0000110) begin
            errors++;
            $display("FAIL branch_over_lw got %b want %b", ctl, 7'b0000110);
        end
        idle_inputs();
    endtask

    task automatic test_mem_wait();
        next_cycle();
        memreq = 1; dmemrdy = 0; pcsrce = 1;
        for (int i = 0; i < 3; i++) begin
            settle();
            checks++;
            if (ctl !== 7'b1111001 || fault !== 1'b0) begin
                errors++;
                $display("FAIL mem_wait_c%0d got ctl=%b fault=%b want 1111001/0", i, ctl, fault);
            end
            next_cycle();
        end
        pcsrce = 0; dmemrdy = 1;
        settle();
        checks++;
        if (ctl !== 7'b0000000) begin
            errors++;
            $display("FAIL mem_ready got %b want %b", ctl, 7'b0000000);
        end
        next_cycle();
        // ready without a request is ignored and back in RUN
        memreq = 0; dmemrdy = 1;
        settle();
        checks++;
        if (ctl !== 7'b0000000 || fault !== 1'b0) begin
            errors++;
            $display("FAIL mem_back_run got ctl=%b fault=%b want 0000000/0", ctl, fault);
        end
        idle_inputs();
    endtask

    task automatic test_timeout();
        next_cycle();
        memreq = 1; dmemrdy = 0;
        for (int i = 0; i < 4; i++) begin
            settle();
            checks++;
            if (ctl !== 7'b1111001 || fault !== 1'b0) begin
                errors++;
                $display("FAIL tmo_wait_c%0d got ctl=%b fault=%b want 1111001/0", i, ctl, fault);
            end
            next_cycle();
        end
        settle();
        checks++;
        if (fault !== 1'b1 || ctl !== 7'b1111001) begin
            errors++;
            $display("FAIL tmo_fault got fault=%b ctl=%b want 1/1111001", fault, ctl);
        end
        // fault is sticky even after the request and a late ready
        next_cycle();
        memreq = 1; dmemrdy = 1;
        settle();
        checks++;
        if (fault !== 1'b1 || ctl !== 7'b1111001) begin
            errors++;
            $display("FAIL tmo_sticky got fault=%b ctl=%b want 1/1111001", fault, ctl);
        end
        next_cycle();
        idle_inputs();
        rst = 1;
        settle();
        checks++;
        if (ctl !== 7'b0000000) begin
            errors++;
            $display("FAIL tmo_rst_cycle got %b want %b", ctl, 7'b0000000);
        end
        next_cycle();
        rst = 0;
        settle();
        checks++;
        if (fault !== 1'b0 || ctl !== 7'b0000000) begin
            errors++;
            $display("FAIL tmo_after_rst got fault=%b ctl=%b want 0/0000000", fault, ctl);
        end
    endtask

    task automatic test_perf_cnt();
        logic [CNT_W-1:0] exp_s, exp_f;
        do_reset();
        // two memory-stall cycles, then completion
        memreq = 1; dmemrdy = 0;
        next_cycle();
        next_cycle();
        dmemrdy = 1;
        next_cycle();
        idle_inputs();
        // one branch flush cycle
        pcsrce = 1;
        next_cycle();
        idle_inputs();
        settle();
`ifdef HAZARD_PERF_CNT_EN
        exp_s = 2; exp_f = 1;
`else
        exp_s = 0; exp_f = 0;
`endif
        checks++;
        if (scnt !== exp_s || fcnt !== exp_f) begin
            errors++;
            $display("FAIL perf_cnt got stall=%0d flush=%0d want %0d/%0d", scnt, fcnt, exp_s, exp_f);
        end
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        #2;
        test_reset();
        test_forwarding();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_timeout();
        test_perf_cnt();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
